// File: rtl/output_display_unit.sv
// output_display_unit: signed 8-bit result to 4-digit multiplexed 7-segment display
// Ports:
//   clock  system clock
//   reset  synchronous active-low reset
//   value  two's-complement result to show
//   err    error flag, captured with value; shows "Err"
//   load   one-cycle request to capture value/err and start conversion
//   seg    segments {g,f,e,d,c,b,a}, active-low, registered
//   an     digit enables, active-low one-hot, an[3] leftmost, registered
//   busy   conversion in progress; load ignored while high
//   done   one-cycle pulse when the display register updates
module output_display_unit #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       err,
    input  logic       load,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy,
    output logic       done
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] DASH  = 7'h3F;
    localparam logic [6:0] CH_E  = 7'h06;
    localparam logic [6:0] CH_R  = 7'h2F;

    typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

    state_t          state_q, state_d;
    logic            err_q, err_d, sign_q, sign_d;
    logic [7:0]      mag_q, mag_d;
    logic [11:0]     bcd_q, bcd_d, adj;
    logic [2:0]      bit_q, bit_d;
    logic [3:0][6:0] disp_q, disp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;
    logic            busy_q, busy_d, done_q, done_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h40;
            4'd1: seg7 = 7'h79;
            4'd2: seg7 = 7'h24;
            4'd3: seg7 = 7'h30;
            4'd4: seg7 = 7'h19;
            4'd5: seg7 = 7'h12;
            4'd6: seg7 = 7'h02;
            4'd7: seg7 = 7'h78;
            4'd8: seg7 = 7'h00;
            4'd9: seg7 = 7'h10;
            default: seg7 = BLANK;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        bit_d   = bit_q;
        disp_d  = disp_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        // double-dabble correction before each shift
        adj[11:8] = bcd_q[11:8] >= 4'd5 ? bcd_q[11:8] + 4'd3 : bcd_q[11:8];
        adj[7:4]  = bcd_q[7:4]  >= 4'd5 ? bcd_q[7:4]  + 4'd3 : bcd_q[7:4];
        adj[3:0]  = bcd_q[3:0]  >= 4'd5 ? bcd_q[3:0]  + 4'd3 : bcd_q[3:0];
        // scan runs independently of conversion; seg/an follow the index one edge later
        cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
        idx_d = cnt_q == LAST ? idx_q + 2'd1 : idx_q;
        an_d  = ~(4'b0001 << idx_q);
        seg_d = disp_q[idx_q];
        case (state_q)
            IDLE: if (load) begin
                err_d   = err;
                sign_d  = value[7];
                mag_d   = value[7] ? ~value + 8'd1 : value;
                bcd_d   = '0;
                bit_d   = '0;
                busy_d  = 1'b1;
                state_d = CONV;
            end
            CONV: begin
                {bcd_d, mag_d} = {adj, mag_q} << 1;
                bit_d   = bit_q + 3'd1;
                state_d = bit_q == 3'd7 ? LATCH : CONV;
            end
            LATCH: begin
                disp_d[3] = err_q ? CH_E : sign_q ? DASH : BLANK;
                disp_d[2] = err_q ? CH_R : bcd_q[11:8] == 4'd0 ? BLANK : seg7(bcd_q[11:8]);
                disp_d[1] = err_q ? CH_R : bcd_q[11:4] == 8'd0 ? BLANK : seg7(bcd_q[7:4]);
                disp_d[0] = err_q ? BLANK : seg7(bcd_q[3:0]);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= '0;
            bit_q   <= '0;
            disp_q  <= {4{BLANK}};
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= BLANK;
            an_q    <= 4'b1110;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            bit_q   <= bit_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_output_display_unit.sv
// tb_output_display_unit: directed checks of conversion timing, digit codes and scan
module tb_output_display_unit;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] value = '0;
    logic       err = 1'b0;
    logic       load = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy, done;
    int         checks = 0;
    int         errors = 0;
    int         dones = 0;

    localparam logic [6:0] BL = 7'h7F;

    output_display_unit #(.SCAN_DIV(4)) dut (
        .clock(clock), .reset(reset), .value(value), .err(err), .load(load),
        .seg(seg), .an(an), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (done === 1'b1) dones++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic convert(input string tag, input logic [7:0] v, input logic e, input int extra);
        int d0;
        @(negedge clock);
        value = v;
        err   = e;
        load  = 1'b1;
        d0    = dones;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i <= 9) check({tag, " busy"}, busy, 1);
            if (i == 9 || i == 10) check({tag, " done"}, done, i == 10);
            if (i == 10) check({tag, " busy end"}, busy, 0);
            load = (i == extra);
            if (i == extra) value = 8'd7;
        end
        load = 1'b0;
        @(negedge clock);
        check({tag, " done drop"}, done, 0);
        check({tag, " one done"}, dones - d0, 1);
    endtask

    task automatic show(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                        input logic [6:0] d1, input logic [6:0] d0);
        logic [6:0] exp [4];
        logic [3:0] a;
        exp[0] = d0; exp[1] = d1; exp[2] = d2; exp[3] = d3;
        for (int d = 0; d < 4; d++) begin
            int n = 0;
            a = ~(4'b0001 << d);
            while (an !== a && n < 40) begin
                @(negedge clock);
                n++;
            end
            check({tag, " an"}, an, a);
            check({tag, " seg"}, seg, exp[d]);
        end
    endtask

    initial begin
        int d0;
        // reset and scan walk with blank digits
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        check("rst seg", seg, BL);
        check("rst an", an, 4'b1110);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        reset = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            logic [3:0] a;
            @(negedge clock);
            a = ~(4'b0001 << ((i - 1) / 4));
            check("walk an", an, a);
            check("walk seg", seg, BL);
        end
        convert("five", 8'd5, 1'b0, 0);
        show("five", BL, BL, BL, 7'h12);
        convert("m13", 8'hF3, 1'b0, 0);
        show("m13", 7'h3F, BL, 7'h79, 7'h30);
        convert("m128", 8'h80, 1'b0, 0);
        show("m128", 7'h3F, 7'h79, 7'h24, 7'h00);
        convert("zero", 8'd0, 1'b0, 0);
        show("zero", BL, BL, BL, 7'h40);
        convert("ign", 8'd123, 1'b0, 3);
        show("ign", BL, 7'h79, 7'h24, 7'h30);
        convert("err", 8'd99, 1'b1, 0);
        show("err", 7'h06, 7'h2F, 7'h2F, BL);
        // reset sampled at edge k+4, mid-conversion
        @(negedge clock);
        value = 8'd50;
        err   = 1'b0;
        load  = 1'b1;
        d0    = dones;
        @(negedge clock);
        load = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("abort busy", busy, 0);
        repeat (12) @(negedge clock);
        check("abort no done", dones - d0, 0);
        show("abort", BL, BL, BL, BL);
        convert("after", 8'd5, 1'b0, 0);
        show("after", BL, BL, BL, 7'h12);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
